// File: rtl/vchk_pkg.sv
// Shared types and constants for the vector checker.
package vchk_pkg;

    localparam int unsigned ERR_W = 16;
    localparam int unsigned ST_W  = 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [ST_W-1:0] {
        VCHK_IDLE        = 3'd0,
        VCHK_APPLY       = 3'd1,
        VCHK_SETTLE_WAIT = 3'd2,
        VCHK_CHECK       = 3'd3,
        VCHK_DONE        = 3'd4
    } vchk_state_t;

endpackage

// File: rtl/vector_checker_if.sv
// Vector memory load port: {stimulus, expected} packed MSB-first.
interface vector_checker_if #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 4,
    parameter int unsigned DEPTH = 256
);
    logic                       load_en;
    logic [$clog2(DEPTH)-1:0]   load_addr;
    logic [IN_W+OUT_W-1:0]      load_data;

    modport master (output load_en, load_addr, load_data);
    modport slave  (input  load_en, load_addr, load_data);
endinterface

// File: rtl/vchk_mem.sv
// DEPTH x W vector memory: one synchronous write port, one asynchronous read port, no reset.
module vchk_mem #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned W     = 12
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/vector_checker.sv
// Applies stored stimulus vectors to an external DUT and compares its response.
// Optional macro VCHK_STOP_ON_FAIL_EN ends a run at the first mismatch.
module vector_checker
    import vchk_pkg::*;
#(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned OUT_W  = 4,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    vector_checker_if.slave          ld,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   num_vec,
    output logic [IN_W-1:0]          dut_a,
    input  logic [OUT_W-1:0]         dut_y,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_W-1:0]         err_count,
    output logic [$clog2(DEPTH)-1:0] fail_idx,
    output logic [OUT_W-1:0]         fail_y,
    output logic [OUT_W-1:0]         fail_exp
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned W  = IN_W + OUT_W;

    localparam logic [ST_W-1:0] IDLE        = VCHK_IDLE;
    localparam logic [ST_W-1:0] APPLY       = VCHK_APPLY;
    localparam logic [ST_W-1:0] SETTLE_WAIT = VCHK_SETTLE_WAIT;
    localparam logic [ST_W-1:0] CHECK       = VCHK_CHECK;
    localparam logic [ST_W-1:0] DONE        = VCHK_DONE;

    logic [ST_W-1:0]  state_q, state_d;
    logic [AW-1:0]    vn_q, vn_d;
    logic [AW:0]      num_q, num_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IN_W-1:0]  dut_a_q, dut_a_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [AW-1:0]    fail_idx_q, fail_idx_d;
    logic [OUT_W-1:0] fail_y_q, fail_y_d;
    logic [OUT_W-1:0] fail_exp_q, fail_exp_d;

    logic [W-1:0]     rdata;
    logic [IN_W-1:0]  stim_c;
    logic [OUT_W-1:0] exp_c;
    logic             we_c;
    logic             mism_c;
    logic [AW:0]      num_clamp_c;

    // Writes are only accepted while no run is in progress.
    assign we_c = ld.load_en && ((state_q == IDLE) || (state_q == DONE));

    vchk_mem #(.DEPTH(DEPTH), .W(W)) u_mem (
        .clk   (clk),
        .we    (we_c),
        .waddr (ld.load_addr),
        .wdata (ld.load_data),
        .raddr (vn_q),
        .rdata (rdata)
    );

    assign stim_c      = rdata[W-1:OUT_W];
    assign exp_c       = rdata[OUT_W-1:0];
    assign mism_c      = (dut_y != exp_c);
    assign num_clamp_c = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;

    always_comb begin
        state_d    = state_q;
        vn_d       = vn_q;
        num_d      = num_q;
        cnt_d      = cnt_q;
        dut_a_d    = dut_a_q;
        err_d      = err_q;
        fail_idx_d = fail_idx_q;
        fail_y_d   = fail_y_q;
        fail_exp_d = fail_exp_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    err_d      = '0;
                    fail_idx_d = '0;
                    fail_y_d   = '0;
                    fail_exp_d = '0;
                    vn_d       = '0;
                    num_d      = num_clamp_c;
                    state_d    = (num_clamp_c == '0) ? DONE : APPLY;
                end
            end
            APPLY: begin
                dut_a_d = stim_c;
                cnt_d   = '0;
                state_d = SETTLE_WAIT;
            end
            SETTLE_WAIT: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) state_d = CHECK;
                else                             cnt_d   = cnt_q + CNT_W'(1);
            end
            CHECK: begin
                if (mism_c) begin
                    if (err_q != '1) err_d = err_q + ERR_W'(1);
                    if (err_q == '0) begin
                        fail_idx_d = vn_q;
                        fail_y_d   = dut_y;
                        fail_exp_d = exp_c;
                    end
                end
                vn_d    = vn_q + AW'(1);
                state_d = ((AW+1)'(vn_q) == num_q - (AW+1)'(1)) ? DONE : APPLY;
`ifdef VCHK_STOP_ON_FAIL_EN
                if (mism_c) state_d = DONE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Status flags are registered alongside the state they describe.
    always_comb begin
        busy_d = (state_d == APPLY) || (state_d == SETTLE_WAIT) || (state_d == CHECK);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vn_q       <= '0;
            num_q      <= '0;
            cnt_q      <= '0;
            dut_a_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fail_idx_q <= '0;
            fail_y_q   <= '0;
            fail_exp_q <= '0;
        end else begin
            state_q    <= state_d;
            vn_q       <= vn_d;
            num_q      <= num_d;
            cnt_q      <= cnt_d;
            dut_a_q    <= dut_a_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            fail_idx_q <= fail_idx_d;
            fail_y_q   <= fail_y_d;
            fail_exp_q <= fail_exp_d;
        end
    end

    assign dut_a     = dut_a_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_idx  = fail_idx_q;
    assign fail_y    = fail_y_q;
    assign fail_exp  = fail_exp_q;

endmodule

// File: tb/tb_vector_checker.sv
// Directed bench for vector_checker driving an 8-input AND gate as the DUT.
module tb_vector_checker;
    import vchk_pkg::*;

`ifdef VCHK_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif
    localparam int LIMIT = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  num_vec = '0;
    logic [7:0]  dut_a;
    logic [0:0]  dut_y;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [7:0]  fail_idx;
    logic [0:0]  fail_y, fail_exp;

    int n_vec = 0;
    int n_err = 0;

    vector_checker_if #(.IN_W(8), .OUT_W(1), .DEPTH(256)) ld_if ();

    vector_checker #(.IN_W(8), .OUT_W(1), .DEPTH(256), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .ld(ld_if.slave), .start(start), .num_vec(num_vec),
        .dut_a(dut_a), .dut_y(dut_y), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_idx(fail_idx), .fail_y(fail_y), .fail_exp(fail_exp)
    );

    assign dut_y = &dut_a;

    always #5 clk = ~clk;

    task automatic load_word(input int a, input logic [8:0] d);
        ld_if.load_en   = 1'b1;
        ld_if.load_addr = 8'(a);
        ld_if.load_data = d;
        @(negedge clk);
        ld_if.load_en   = 1'b0;
    endtask

    // Starts a run and counts cycles until done; optionally injects start+load while busy.
    task automatic run_vec(input logic [8:0] n, input int inject_at, output int cyc);
        num_vec = n;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < LIMIT) begin
            if (cyc == inject_at) begin
                start           = 1'b1;
                num_vec         = 9'd1;
                ld_if.load_en   = 1'b1;
                ld_if.load_addr = 8'd10;
                ld_if.load_data = {8'd10, 1'b1};
            end
            @(negedge clk);
            start         = 1'b0;
            ld_if.load_en = 1'b0;
            cyc++;
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL run_timeout: done=%0b after %0d cycles, required 1", done, cyc);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %0b want 0", done); end
        n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL rst_pass: got %0b want 0", pass); end
        n_vec++; if (err_count !== 16'd0) begin n_err++; $display("FAIL rst_err: got %0d want 0", err_count); end
        n_vec++; if (dut_a !== 8'd0) begin n_err++; $display("FAIL rst_dut_a: got %0h want 0", dut_a); end
        n_vec++; if ({fail_idx, fail_y, fail_exp} !== 10'd0) begin
            n_err++; $display("FAIL rst_fail_capture: got %0h want 0", {fail_idx, fail_y, fail_exp});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Load and start in the same IDLE cycle: the new word must be the one checked.
    task automatic test_load_start_same_cycle();
        int cyc;
        ld_if.load_en   = 1'b1;
        ld_if.load_addr = 8'd0;
        ld_if.load_data = {8'd0, 1'b1};
        num_vec = 9'd1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0; ld_if.load_en = 1'b0;
        cyc = 1;
        while (!done && cyc < LIMIT) begin @(negedge clk); cyc++; end
        n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL same_cycle_latency: got %0d want 4", cyc); end
        n_vec++; if (err_count !== 16'd1) begin n_err++; $display("FAIL same_cycle_err: got %0d want 1", err_count); end
        n_vec++; if (fail_exp !== 1'b1 || fail_y !== 1'b0) begin
            n_err++; $display("FAIL same_cycle_capture: got y=%0b exp=%0b want y=0 exp=1", fail_y, fail_exp);
        end
    endtask

    task automatic test_full_pass();
        int cyc;
        for (int i = 0; i < 256; i++) load_word(i, {8'(i), (i == 255) ? 1'b1 : 1'b0});
        run_vec(9'd256, -1, cyc);
        n_vec++; if (cyc !== 769) begin n_err++; $display("FAIL full_latency: got %0d want 769", cyc); end
        n_vec++; if (err_count !== 16'd0) begin n_err++; $display("FAIL full_err: got %0d want 0", err_count); end
        n_vec++; if (pass !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL full_status: got pass=%0b busy=%0b want pass=1 busy=0", pass, busy);
        end
        run_vec(9'd300, -1, cyc);
        n_vec++; if (cyc !== 769) begin n_err++; $display("FAIL clamp_latency: got %0d want 769", cyc); end
        n_vec++; if (pass !== 1'b1) begin n_err++; $display("FAIL clamp_pass: got %0b want 1", pass); end
    endtask

    task automatic test_first_fail();
        int cyc;
        load_word(37, {8'd37, 1'b1});
        run_vec(9'd256, -1, cyc);
        n_vec++; if (err_count !== 16'd1) begin n_err++; $display("FAIL ff_err: got %0d want 1", err_count); end
        n_vec++; if (fail_idx !== 8'd37) begin n_err++; $display("FAIL ff_idx: got %0d want 37", fail_idx); end
        n_vec++; if (fail_exp !== 1'b1 || fail_y !== 1'b0) begin
            n_err++; $display("FAIL ff_capture: got y=%0b exp=%0b want y=0 exp=1", fail_y, fail_exp);
        end
        n_vec++; if (pass !== 1'b0 || done !== 1'b1) begin
            n_err++; $display("FAIL ff_status: got pass=%0b done=%0b want pass=0 done=1", pass, done);
        end
        n_vec++; if (cyc !== (STOP ? 115 : 769)) begin
            n_err++; $display("FAIL ff_latency: got %0d want %0d", cyc, STOP ? 115 : 769);
        end
        load_word(37, {8'd37, 1'b0});
    endtask

    task automatic test_zero_vectors();
        int cyc;
        logic [7:0] exp_a;
        exp_a = STOP ? 8'd37 : 8'd255;
        run_vec(9'd0, -1, cyc);
        n_vec++; if (cyc !== 1) begin n_err++; $display("FAIL zero_latency: got %0d want 1", cyc); end
        n_vec++; if (pass !== 1'b1 || err_count !== 16'd0) begin
            n_err++; $display("FAIL zero_status: got pass=%0b err=%0d want pass=1 err=0", pass, err_count);
        end
        n_vec++; if (dut_a !== exp_a) begin n_err++; $display("FAIL zero_dut_a: got %0d want %0d", dut_a, exp_a); end
    endtask

    task automatic test_reset_mid_run();
        int k;
        int cyc;
        bit quiet;
        if (!STOP) load_word(2, {8'd2, 1'b1});
        num_vec = 9'd20;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (dut_a !== 8'd5 && k < LIMIT) begin @(negedge clk); k++; end
        n_vec++; if (dut_a !== 8'd5) begin n_err++; $display("FAIL midrst_reach: got dut_a=%0d want 5", dut_a); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL midrst_flags: got busy=%0b done=%0b want 0 0", busy, done);
        end
        n_vec++; if (err_count !== 16'd0) begin n_err++; $display("FAIL midrst_err: got %0d want 0", err_count); end
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (6) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0; end
        n_vec++; if (!quiet) begin n_err++; $display("FAIL midrst_no_done: got activity after abort, want none"); end
        run_vec(9'd3, -1, cyc);
        n_vec++; if (cyc !== 10) begin n_err++; $display("FAIL rerun_latency: got %0d want 10", cyc); end
        n_vec++; if (err_count !== (STOP ? 16'd0 : 16'd1)) begin
            n_err++; $display("FAIL rerun_err: got %0d want %0d", err_count, STOP ? 0 : 1);
        end
        n_vec++; if (fail_idx !== (STOP ? 8'd0 : 8'd2)) begin
            n_err++; $display("FAIL rerun_idx: got %0d want %0d", fail_idx, STOP ? 0 : 2);
        end
        load_word(2, {8'd2, 1'b0});
    endtask

    task automatic test_busy_ignore();
        int cyc;
        run_vec(9'd30, 5, cyc);
        n_vec++; if (cyc !== 91) begin n_err++; $display("FAIL busy_latency: got %0d want 91", cyc); end
        n_vec++; if (err_count !== 16'd0 || pass !== 1'b1) begin
            n_err++; $display("FAIL busy_run: got err=%0d pass=%0b want 0 1", err_count, pass);
        end
        run_vec(9'd30, -1, cyc);
        n_vec++; if (err_count !== 16'd0) begin n_err++; $display("FAIL busy_mem_kept: got err=%0d want 0", err_count); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        load_word(3, {8'd3, 1'b1});
        load_word(9, {8'd9, 1'b1});
        run_vec(9'd12, -1, cyc);
        n_vec++; if (err_count !== (STOP ? 16'd1 : 16'd2)) begin
            n_err++; $display("FAIL b2b_err: got %0d want %0d", err_count, STOP ? 1 : 2);
        end
        n_vec++; if (fail_idx !== 8'd3) begin n_err++; $display("FAIL b2b_idx: got %0d want 3", fail_idx); end
        n_vec++; if (cyc !== (STOP ? 13 : 37)) begin
            n_err++; $display("FAIL b2b_latency: got %0d want %0d", cyc, STOP ? 13 : 37);
        end
        n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL b2b_pass: got %0b want 0", pass); end
        load_word(3, {8'd3, 1'b0});
        load_word(9, {8'd9, 1'b0});
        run_vec(9'd12, -1, cyc);
        n_vec++; if (err_count !== 16'd0 || fail_idx !== 8'd0) begin
            n_err++; $display("FAIL b2b_clear: got err=%0d idx=%0d want 0 0", err_count, fail_idx);
        end
        n_vec++; if (pass !== 1'b1 || cyc !== 37) begin
            n_err++; $display("FAIL b2b_rerun: got pass=%0b cyc=%0d want 1 37", pass, cyc);
        end
    endtask

    initial begin
        ld_if.load_en   = 1'b0;
        ld_if.load_addr = '0;
        ld_if.load_data = '0;
        test_reset();
        test_load_start_same_cycle();
        test_full_pass();
        test_first_fail();
        test_zero_vectors();
        test_reset_mid_run();
        test_busy_ignore();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
